// File: rtl/sha1_cycle.sv
// One SHA-1 round per clock, with load/phase_advance/Din delay-aligned to the A update.
// Optional digest feed-forward on R is enabled by defining SHA1_FEEDFORWARD_EN.
module sha1_cycle #(
  parameter int LATENCY = 7
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] R,
  input  logic [31:0] Din,
  input  logic        load,
  input  logic        phase_advance,
  output logic [1:0]  phase_out
);

  // Control bits need LATENCY-1 registers; Din is sampled one edge later, so one fewer.
  localparam int CTRL_DEPTH = LATENCY - 1;
  localparam int DIN_DEPTH  = LATENCY - 2;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hEFCDAB89;
  localparam logic [31:0] IV_C = 32'h98BADCFE;
  localparam logic [31:0] IV_D = 32'h10325476;
  localparam logic [31:0] IV_E = 32'hC3D2E1F0;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic logic [31:0] rotl30(input logic [31:0] x);
    return {x[1:0], x[31:2]};
  endfunction

  logic [CTRL_DEPTH-1:0] load_pipe_q, load_pipe_d;
  logic [CTRL_DEPTH-1:0] adv_pipe_q, adv_pipe_d;
  logic [31:0]           din_pipe_q [DIN_DEPTH];
  logic                  load_prev_q;
  logic [31:0]           sched_q [16];
  logic [31:0]           a_q, b_q, c_q, d_q, e_q;
  logic [31:0]           a_d, b_d, c_d, d_d, e_d;
  logic [1:0]            phase_q, phase_d;
  logic [1:0]            phase_out_q;

  logic        load_al, adv_al, blk_start;
  logic [31:0] din_al;
  logic [31:0] ra, rb, rc, rd, re;
  logic [31:0] w_t, f_t, k_t, t_val;

  assign load_al   = load_pipe_q[CTRL_DEPTH-1];
  assign adv_al    = adv_pipe_q[CTRL_DEPTH-1];
  assign din_al    = din_pipe_q[DIN_DEPTH-1];
  assign blk_start = load_al & ~load_prev_q;

  always_comb begin
    load_pipe_d = {load_pipe_q[CTRL_DEPTH-2:0], load};
    adv_pipe_d  = {adv_pipe_q[CTRL_DEPTH-2:0], phase_advance};
    phase_d     = phase_q;
    if (adv_al) phase_d = phase_q + 2'd1;
  end

  // Round input state: IV on the first aligned load of a block, registers otherwise.
  always_comb begin
    ra = a_q;
    rb = b_q;
    rc = c_q;
    rd = d_q;
    re = e_q;
    if (blk_start) begin
      ra = IV_A;
      rb = IV_B;
      rc = IV_C;
      rd = IV_D;
      re = IV_E;
    end
  end

  // sched_q[i] holds W[t-1-i].
  always_comb begin
    w_t = rotl1(sched_q[2] ^ sched_q[7] ^ sched_q[13] ^ sched_q[15]);
    if (load_al) w_t = din_al;
  end

  always_comb begin
    f_t = rb ^ rc ^ rd;
    k_t = 32'h6ED9EBA1;
    case (phase_q)
      2'd0: begin
        f_t = (rb & rc) | (~rb & rd);
        k_t = 32'h5A827999;
      end
      2'd1: begin
        f_t = rb ^ rc ^ rd;
        k_t = 32'h6ED9EBA1;
      end
      2'd2: begin
        f_t = (rb & rc) | (rb & rd) | (rc & rd);
        k_t = 32'h8F1BBCDC;
      end
      default: begin
        f_t = rb ^ rc ^ rd;
        k_t = 32'hCA62C1D6;
      end
    endcase
  end

  always_comb begin
    t_val = rotl5(ra) + f_t + re + k_t + w_t;
    a_d   = t_val;
    b_d   = ra;
    c_d   = rotl30(rb);
    d_d   = rc;
    e_d   = rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_pipe_q <= '0;
      adv_pipe_q  <= '0;
      load_prev_q <= 1'b0;
      for (int i = 0; i < DIN_DEPTH; i++) din_pipe_q[i] <= '0;
      for (int i = 0; i < 16; i++) sched_q[i] <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      e_q         <= '0;
      phase_q     <= 2'd0;
      phase_out_q <= 2'd0;
    end else begin
      load_pipe_q <= load_pipe_d;
      adv_pipe_q  <= adv_pipe_d;
      load_prev_q <= load_al;
      din_pipe_q[0] <= Din;
      for (int i = 1; i < DIN_DEPTH; i++) din_pipe_q[i] <= din_pipe_q[i-1];
      sched_q[0] <= w_t;
      for (int i = 1; i < 16; i++) sched_q[i] <= sched_q[i-1];
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      e_q         <= e_d;
      phase_q     <= phase_d;
      phase_out_q <= phase_q;
    end
  end

  assign phase_out = phase_out_q;

`ifdef SHA1_FEEDFORWARD_EN
  logic [6:0]  rnd_q, rnd_d;
  logic        active_q, active_d;
  logic        hold_q, hold_d;
  logic [31:0] r_q, r_d;
  logic [6:0]  rnd_idx;
  logic        in_block;

  assign rnd_idx  = blk_start ? 7'd0 : rnd_q;
  assign in_block = blk_start | active_q;

  // After round 79 R carries the first digest word until the next block starts.
  always_comb begin
    rnd_d    = rnd_q;
    active_d = active_q;
    hold_d   = hold_q;
    r_d      = t_val;
    if (in_block && rnd_idx == 7'd79) begin
      r_d      = t_val + IV_A;
      active_d = 1'b0;
      hold_d   = 1'b1;
      rnd_d    = 7'd0;
    end else if (blk_start) begin
      rnd_d    = 7'd1;
      active_d = 1'b1;
      hold_d   = 1'b0;
    end else if (active_q) begin
      rnd_d    = rnd_q + 7'd1;
    end else if (hold_q) begin
      r_d      = r_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rnd_q    <= '0;
      active_q <= 1'b0;
      hold_q   <= 1'b0;
      r_q      <= '0;
    end else begin
      rnd_q    <= rnd_d;
      active_q <= active_d;
      hold_q   <= hold_d;
      r_q      <= r_d;
    end
  end

  assign R = r_q;
`else
  assign R = a_q;
`endif

endmodule

// File: tb/tb_sha1_cycle.sv
// Bench for sha1_cycle: scripted blocks with random message words and random filler Din,
// checked against a per-block software SHA-1 round model.
module tb_sha1_cycle;

  localparam int NCYC = 440;
  localparam int NBLK = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] R;
  logic [31:0] Din;
  logic        load;
  logic        phase_advance;
  logic [1:0]  phase_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  logic        ld_h  [NCYC];
  logic        pa_h  [NCYC];
  logic [31:0] din_h [NCYC];
  logic        chk_r [NCYC+1];
  int          blk_s [NBLK];
  logic [31:0] blk_w [NBLK][16];

  sha1_cycle dut (
    .clk           (clk),
    .reset         (reset),
    .R             (R),
    .Din           (Din),
    .load          (load),
    .phase_advance (phase_advance),
    .phase_out     (phase_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Phase used by the round at edge e: pulses take effect 7 edges after sampling.
  function automatic logic [1:0] phase_at(input int e);
    int cnt = 0;
    for (int c = 0; c <= e - 8 && c < NCYC; c++) cnt += int'(pa_h[c]);
    return 2'(cnt);
  endfunction

  task automatic build_plan();
    logic [31:0] tv [16];
    tv[0] = 32'h54686973; tv[1] = 32'h20697320; tv[2] = 32'h61207465;
    tv[3] = 32'h73742E0A; tv[4] = 32'h80000000;
    for (int i = 5; i < 15; i++) tv[i] = 32'h0;
    tv[15] = 32'h00000080;
    blk_s[0] = 10; blk_s[1] = 90; blk_s[2] = 170; blk_s[3] = 250; blk_s[4] = 350;
    for (int c = 0; c < NCYC; c++) begin
      ld_h[c]  = 1'b0;
      pa_h[c]  = 1'b0;
      din_h[c] = $urandom;
    end
    for (int c = 0; c <= NCYC; c++) chk_r[c] = 1'b0;
    for (int b = 0; b < NBLK; b++) begin
      for (int i = 0; i < 16; i++) begin
        blk_w[b][i] = (b < 2) ? tv[i] : $urandom;
        ld_h[blk_s[b] + i]      = 1'b1;
        din_h[blk_s[b] + 1 + i] = blk_w[b][i];
      end
      for (int g = 0; g < 4; g++) pa_h[blk_s[b] + 19 + 20*g] = 1'b1;
    end
    // phase_advance coinciding with the first load cycle of block 3
    pa_h[blk_s[3]] = 1'b1;
  endtask

  task automatic run_model();
    logic [31:0] w [80];
    logic [31:0] ma, mb, mc, md, me, f, k, tmp;
    int          edge_n;
    for (int b = 0; b < NBLK; b++) begin
      for (int t = 0; t < 80; t++)
        w[t] = (t < 16) ? blk_w[b][t] : rol(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
      ma = 32'h67452301; mb = 32'hEFCDAB89; mc = 32'h98BADCFE;
      md = 32'h10325476; me = 32'hC3D2E1F0;
      for (int t = 0; t < 80; t++) begin
        edge_n = blk_s[b] + 7 + t;
        case (phase_at(edge_n))
          2'd0: begin f = (mb & mc) | (~mb & md); k = 32'h5A827999; end
          2'd1: begin f = mb ^ mc ^ md; k = 32'h6ED9EBA1; end
          2'd2: begin f = (mb & mc) | (mb & md) | (mc & md); k = 32'h8F1BBCDC; end
          default: begin f = mb ^ mc ^ md; k = 32'hCA62C1D6; end
        endcase
        tmp = rol(ma, 5) + f + me + k + w[t];
        me = md; md = mc; mc = rol(mb, 30); mb = ma; ma = tmp;
        if (edge_n <= NCYC) begin
          chk_r[edge_n] = 1'b1;
`ifdef SHA1_FEEDFORWARD_EN
          exp_q.push_back((t == 79) ? ma + 32'h67452301 : ma);
`else
          exp_q.push_back(ma);
`endif
        end
      end
    end
  endtask

  initial begin
    logic [31:0] expv;
    build_plan();
    run_model();

    reset = 1'b1;
    load = 1'b1;
    phase_advance = 1'b1;
    Din = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_R", R, 32'h0);
    check_eq("reset_phase", 32'(phase_out), 32'h0);

    reset = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      load          = ld_h[c];
      phase_advance = pa_h[c];
      Din           = din_h[c];
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("phase_e%0d", c + 1), 32'(phase_out), 32'(phase_at(c + 1)));
      if (chk_r[c + 1]) begin
        if (exp_q.size() == 0) begin
          check_eq($sformatf("expq_empty_e%0d", c + 1), 32'(exp_q.size()), 32'h1);
        end else begin
          expv = exp_q.pop_front();
          check_eq($sformatf("R_e%0d", c + 1), R, expv);
        end
      end
      if (c + 1 == blk_s[0] + 7 || c + 1 == blk_s[1] + 7)
        check_eq($sformatf("first_round_e%0d", c + 1), R, 32'hF41D0226);
    end
    check_eq("expq_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
